// File: rtl/mpu6050_pkg.sv
// Shared definitions for the MPU6050 sensor path: register map,
// bus addressing and the accelerometer sampler state encoding.
package mpu6050_pkg;

  localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] ACCEL_XOUT_L = 8'h3C;
  localparam logic [7:0] ACCEL_YOUT_H = 8'h3D;
  localparam logic [7:0] ACCEL_YOUT_L = 8'h3E;
  localparam logic [7:0] ACCEL_ZOUT_H = 8'h3F;
  localparam logic [7:0] ACCEL_ZOUT_L = 8'h40;
  localparam logic [7:0] PWR_MGMT_1   = 8'h6B;

  localparam logic [6:0] MPU6050_SLAVE_ADDR = 7'h68;

  // Number of single-byte reads that make up one accelerometer burst.
  localparam int unsigned ACCEL_BYTES = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } sampler_state_e;

  // Magnitude of the signed difference cur - prev, computed one bit wider
  // so that full-scale swings (e.g. 0x7FFF to 0x8000) cannot overflow.
  function automatic logic [16:0] abs_delta(input logic [15:0] cur,
                                            input logic [15:0] prev);
    logic signed [16:0] d;
    d = $signed({cur[15], cur}) - $signed({prev[15], prev});
    return d[16] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/mpu6050_sampler_if.sv
// Request/response handshake between a register-read requester and i2c_master.
// The master modport is the requesting side (the sampler); the slave modport
// is the i2c_master side that performs the bus transaction.
interface mpu6050_sampler_if;
  logic       master_start;
  logic [7:0] master_reg_addr;
  logic       master_available;
  logic       master_data_valid;
  logic [7:0] master_data;

  modport master (
    output master_start,
    output master_reg_addr,
    input  master_available,
    input  master_data_valid,
    input  master_data
  );

  modport slave (
    input  master_start,
    input  master_reg_addr,
    output master_available,
    output master_data_valid,
    output master_data
  );
endinterface

// File: rtl/mpu6050_sampler_period_tick.sv
// Free-running 0..PERIOD-1 counter; tick is high for the single wrap cycle.
module period_tick #(
  parameter int unsigned PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count wraps to zero after the last value of the period.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Counter register, cleared by the active-low asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/mpu6050_sampler.sv
// Periodic accelerometer sampler: reads ACCEL_XOUT_H..ACCEL_ZOUT_L through
// i2c_master, publishes three signed axis words and flags X/Y shakes.
import mpu6050_pkg::*;

module mpu6050_sampler #(
  parameter int unsigned SAMPLE_PERIOD   = 5_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 500_000,
  parameter logic [15:0] SHAKE_THRESHOLD = 16'd8000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_giroscopio,
  mpu6050_sampler_if.master   bus,
  output logic [15:0]         accel_x,
  output logic [15:0]         accel_y,
  output logic [15:0]         accel_z,
  output logic                sample_valid,
  output logic                shake_detected,
  output logic                busy,
  output logic                i2c_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES);

  sampler_state_e state_q;
  logic [2:0]     idx_q;
  logic [TW-1:0]  tout_q;
  logic           start_q;
  logic [7:0]     reg_addr_q;
  logic [7:0]     shadow_q [ACCEL_BYTES];
  logic [15:0]    prev_x_q;
  logic [15:0]    prev_y_q;
  logic           prev_valid_q;

  logic           tick;
  logic           timed_out;
  logic           shake_now;
  logic [15:0]    new_x;
  logic [15:0]    new_y;
  logic [15:0]    new_z;

  period_tick #(.PERIOD(SAMPLE_PERIOD)) u_period_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign bus.master_start    = start_q;
  assign bus.master_reg_addr = reg_addr_q;

  // Assemble the shadow bytes big-endian and decide whether this burst is a shake.
  always_comb begin
    new_x     = {shadow_q[0], shadow_q[1]};
    new_y     = {shadow_q[2], shadow_q[3]};
    new_z     = {shadow_q[4], shadow_q[5]};
    timed_out = (tout_q == TOUT_LAST);
    shake_now = prev_valid_q &&
                ((abs_delta(new_x, prev_x_q) > {1'b0, SHAKE_THRESHOLD}) ||
                 (abs_delta(new_y, prev_y_q) > {1'b0, SHAKE_THRESHOLD}));
  end

  // Burst sequencer: one request/wait pair per byte, with per-byte timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      tout_q         <= '0;
      start_q        <= 1'b0;
      reg_addr_q     <= ACCEL_XOUT_H;
      for (int i = 0; i < ACCEL_BYTES; i++) shadow_q[i] <= '0;
      accel_x        <= '0;
      accel_y        <= '0;
      accel_z        <= '0;
      prev_x_q       <= '0;
      prev_y_q       <= '0;
      prev_valid_q   <= 1'b0;
      sample_valid   <= 1'b0;
      shake_detected <= 1'b0;
      busy           <= 1'b0;
      i2c_error      <= 1'b0;
    end else begin
      sample_valid   <= 1'b0;
      shake_detected <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick && enable_giroscopio) begin
            idx_q      <= '0;
            tout_q     <= '0;
            reg_addr_q <= ACCEL_XOUT_H;
            busy       <= 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (timed_out) begin
            start_q <= 1'b0;
            state_q <= ST_ERR;
          end else if (start_q && !bus.master_available) begin
            start_q <= 1'b0;
            tout_q  <= tout_q + TW'(1);
            state_q <= ST_WAIT;
          end else begin
            start_q <= bus.master_available;
            tout_q  <= tout_q + TW'(1);
          end
        end
        ST_WAIT: begin
          if (bus.master_data_valid) begin
            shadow_q[idx_q] <= bus.master_data;
            state_q         <= ST_NEXT;
          end else if (timed_out) begin
            state_q <= ST_ERR;
          end else begin
            tout_q <= tout_q + TW'(1);
          end
        end
        ST_NEXT: begin
          if (idx_q == 3'd5) begin
            state_q <= ST_DONE;
          end else begin
            idx_q      <= idx_q + 3'd1;
            reg_addr_q <= ACCEL_XOUT_H + {5'd0, idx_q + 3'd1};
            tout_q     <= '0;
            state_q    <= ST_REQ;
          end
        end
        ST_DONE: begin
          accel_x        <= new_x;
          accel_y        <= new_y;
          accel_z        <= new_z;
          sample_valid   <= 1'b1;
          shake_detected <= shake_now;
          prev_x_q       <= new_x;
          prev_y_q       <= new_y;
          prev_valid_q   <= 1'b1;
          i2c_error      <= 1'b0;
          busy           <= 1'b0;
          reg_addr_q     <= ACCEL_XOUT_H;
          state_q        <= ST_IDLE;
        end
        ST_ERR: begin
          i2c_error  <= 1'b1;
          start_q    <= 1'b0;
          busy       <= 1'b0;
          reg_addr_q <= ACCEL_XOUT_H;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu6050_sampler.sv
// Bench for mpu6050_sampler: behavioural i2c_master models drive two sampler
// instances (normal period / back-to-back period); results are compared
// against a small arithmetic reference model of the sampling rules.
module tb_mpu6050_sampler;

  localparam int PERIOD1 = 200;
  localparam int PERIOD2 = 2;
  localparam int TOUT    = 100;
  localparam int THRESH  = 8000;
  localparam int LAT1    = 3;
  localparam int LAT2    = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en1 = 1'b0;
  logic en2 = 1'b0;

  always #5 clk = ~clk;

  mpu6050_sampler_if bus1 ();
  mpu6050_sampler_if bus2 ();

  logic [15:0] ax1, ay1, az1, ax2, ay2, az2;
  logic sv1, sh1, busy1, err1, sv2, sh2, busy2, err2;

  mpu6050_sampler #(
    .SAMPLE_PERIOD(PERIOD1), .TIMEOUT_CYCLES(TOUT), .SHAKE_THRESHOLD(16'd8000)
  ) dut (
    .clk(clk), .reset(reset), .enable_giroscopio(en1), .bus(bus1),
    .accel_x(ax1), .accel_y(ay1), .accel_z(az1), .sample_valid(sv1),
    .shake_detected(sh1), .busy(busy1), .i2c_error(err1)
  );

  mpu6050_sampler #(
    .SAMPLE_PERIOD(PERIOD2), .TIMEOUT_CYCLES(TOUT), .SHAKE_THRESHOLD(16'd8000)
  ) dut2 (
    .clk(clk), .reset(reset), .enable_giroscopio(en2), .bus(bus2),
    .accel_x(ax2), .accel_y(ay2), .accel_z(az2), .sample_valid(sv2),
    .shake_detected(sh2), .busy(busy2), .i2c_error(err2)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem1 [6];
  logic [7:0] mem2 [6];
  int drop_idx = -1;
  logic [7:0] acc_q [$];
  logic [7:0] acc2_q [$];

  logic signed [15:0] prev_x, prev_y;
  bit have_prev = 1'b0;
  logic [15:0] last_x = 16'h0, last_y = 16'h0, last_z = 16'h0;

  int m1_cnt = 0, m2_cnt = 0, m1_idx, m2_idx;
  logic [7:0] m1_addr, m2_addr;

  // Master model for dut: accepts start when idle, answers after LAT1 cycles.
  always @(negedge clk) begin
    bus1.master_data_valid = 1'b0;
    if (!reset) begin
      bus1.master_available = 1'b1;
      m1_cnt = 0;
    end else if (m1_cnt > 0) begin
      m1_cnt--;
      if (m1_cnt == 0) begin
        m1_idx = int'(m1_addr) - 'h3B;
        if (m1_idx != drop_idx && m1_idx >= 0 && m1_idx < 6) begin
          bus1.master_data_valid = 1'b1;
          bus1.master_data = mem1[m1_idx];
        end
        bus1.master_available = 1'b1;
      end
    end else if (bus1.master_available && bus1.master_start) begin
      bus1.master_available = 1'b0;
      m1_cnt = LAT1;
      m1_addr = bus1.master_reg_addr;
      acc_q.push_back(bus1.master_reg_addr);
    end
  end

  // Slow master model for dut2.
  always @(negedge clk) begin
    bus2.master_data_valid = 1'b0;
    if (!reset) begin
      bus2.master_available = 1'b1;
      m2_cnt = 0;
    end else if (m2_cnt > 0) begin
      m2_cnt--;
      if (m2_cnt == 0) begin
        m2_idx = int'(m2_addr) - 'h3B;
        if (m2_idx >= 0 && m2_idx < 6) begin
          bus2.master_data_valid = 1'b1;
          bus2.master_data = mem2[m2_idx];
        end
        bus2.master_available = 1'b1;
      end
    end else if (bus2.master_available && bus2.master_start) begin
      bus2.master_available = 1'b0;
      m2_cnt = LAT2;
      m2_addr = bus2.master_reg_addr;
      acc2_q.push_back(bus2.master_reg_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    mem1[0] = x[15:8]; mem1[1] = x[7:0];
    mem1[2] = y[15:8]; mem1[3] = y[7:0];
    mem1[4] = z[15:8]; mem1[5] = z[7:0];
  endtask

  // Wait for one complete burst on dut and compare it with the reference model.
  task automatic good_burst(input string tag, input bit check_addrs, input bit clear_q);
    logic signed [15:0] ex, ey, ez;
    int dx, dy;
    bit exp_shk, got, shk;
    ex = {mem1[0], mem1[1]};
    ey = {mem1[2], mem1[3]};
    ez = {mem1[4], mem1[5]};
    dx = int'(ex) - int'(prev_x);
    dy = int'(ey) - int'(prev_y);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    exp_shk = have_prev && (dx > THRESH || dy > THRESH);
    if (clear_q) acc_q.delete();
    got = 1'b0;
    shk = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      if (sv1) begin got = 1'b1; shk = sh1; end
    end
    check({tag, ".valid"},   32'(got), 32'd1);
    check({tag, ".accel_x"}, {16'h0, ax1}, {16'h0, ex});
    check({tag, ".accel_y"}, {16'h0, ay1}, {16'h0, ey});
    check({tag, ".accel_z"}, {16'h0, az1}, {16'h0, ez});
    check({tag, ".shake"},   32'(shk), 32'(exp_shk));
    check({tag, ".error"},   32'(err1), 32'd0);
    check({tag, ".accepts"}, 32'(acc_q.size()), 32'd6);
    if (check_addrs) begin
      for (int i = 0; i < 6; i++) begin
        if (i < acc_q.size()) check({tag, ".addr"}, {24'h0, acc_q[i]}, 32'h3B + 32'(i));
      end
    end
    @(negedge clk);
    check({tag, ".pulse_width"}, 32'(sv1), 32'd0);
    prev_x = ex; prev_y = ey; have_prev = 1'b1;
    last_x = ex; last_y = ey; last_z = ez;
  endtask

  initial begin
    bit got_err, saw, found, got;
    int c;
    bus1.master_available = 1'b1; bus1.master_data_valid = 1'b0; bus1.master_data = 8'h00;
    bus2.master_available = 1'b1; bus2.master_data_valid = 1'b0; bus2.master_data = 8'h00;
    prev_x = 16'sh0; prev_y = 16'sh0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst.start",    32'(bus1.master_start), 32'd0);
    check("rst.reg_addr", {24'h0, bus1.master_reg_addr}, 32'h3B);
    check("rst.accel_x",  {16'h0, ax1}, 32'h0);
    check("rst.accel_y",  {16'h0, ay1}, 32'h0);
    check("rst.accel_z",  {16'h0, az1}, 32'h0);
    check("rst.busy",     32'(busy1), 32'd0);
    check("rst.error",    32'(err1), 32'd0);
    check("rst.valid",    32'(sv1), 32'd0);
    reset = 1'b1;
    en1 = 1'b1;

    // Directed burst, address sequence and first-sample shake suppression.
    set_mem(16'h1234, 16'hFEDC, 16'h4000);
    good_burst("b1", 1'b1, 1'b1);
    set_mem(16'h0000, 16'hFEDC, 16'h4000);
    good_burst("b2", 1'b0, 1'b1);
    set_mem(16'h2000, 16'hFEDC, 16'h4000);
    good_burst("b3_d8192", 1'b0, 1'b1);
    set_mem(16'h3F40, 16'hFEDC, 16'h4000);
    good_burst("b4_d8000", 1'b0, 1'b1);
    set_mem(16'h3F40, 16'hDF9B, 16'h4000);
    good_burst("b5_dy8001", 1'b0, 1'b1);

    // Randomized bursts.
    for (int k = 0; k < 4; k++) begin
      set_mem(16'($urandom), 16'($urandom), 16'($urandom));
      good_burst("rand", 1'b0, 1'b1);
    end

    // Byte 3 never answered: timeout, outputs held, then recovery.
    set_mem(16'($urandom), 16'($urandom), 16'($urandom));
    drop_idx = 3;
    acc_q.delete();
    got_err = 1'b0;
    saw = 1'b0;
    for (c = 0; c < 1000 && !got_err; c++) begin
      @(negedge clk);
      if (sv1) saw = 1'b1;
      if (err1) got_err = 1'b1;
    end
    check("tout.error",   32'(got_err), 32'd1);
    check("tout.no_valid", 32'(saw), 32'd0);
    check("tout.accel_x", {16'h0, ax1}, {16'h0, last_x});
    check("tout.accel_y", {16'h0, ay1}, {16'h0, last_y});
    check("tout.accel_z", {16'h0, az1}, {16'h0, last_z});
    check("tout.busy",    32'(busy1), 32'd0);
    check("tout.accepts", 32'(acc_q.size()), 32'd4);
    drop_idx = -1;
    good_burst("recover", 1'b0, 1'b1);

    // Enable drops during byte 2: burst completes, no further bursts.
    set_mem(16'($urandom), 16'($urandom), 16'($urandom));
    acc_q.delete();
    c = 0;
    while (acc_q.size() < 3 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("en_drop.reached", 32'(acc_q.size() >= 3), 32'd1);
    en1 = 1'b0;
    good_burst("en_drop", 1'b0, 1'b0);
    saw = 1'b0;
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      if (sv1 || busy1) saw = 1'b1;
    end
    check("en_drop.quiet", 32'(saw), 32'd0);

    // Reset asserted while waiting for a byte.
    en1 = 1'b1;
    set_mem(16'($urandom), 16'($urandom), 16'($urandom));
    found = 1'b0;
    for (c = 0; c < 1000 && !found; c++) begin
      @(posedge clk);
      #2;
      if (busy1 && !bus1.master_available && !bus1.master_start) found = 1'b1;
    end
    check("wrst.in_wait", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    check("wrst.start",    32'(bus1.master_start), 32'd0);
    check("wrst.reg_addr", {24'h0, bus1.master_reg_addr}, 32'h3B);
    check("wrst.busy",     32'(busy1), 32'd0);
    check("wrst.accel_x",  {16'h0, ax1}, 32'h0);
    check("wrst.accel_y",  {16'h0, ay1}, 32'h0);
    check("wrst.accel_z",  {16'h0, az1}, 32'h0);
    check("wrst.error",    32'(err1), 32'd0);
    check("wrst.valid",    32'(sv1), 32'd0);
    check("wrst.shake",    32'(sh1), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    have_prev = 1'b0;
    last_x = 16'h0; last_y = 16'h0; last_z = 16'h0;

    // First burst after reset never flags shake, even at full scale.
    set_mem(16'h8000, 16'($urandom), 16'($urandom));
    good_burst("post_rst", 1'b1, 1'b1);
    en1 = 1'b0;

    // Period of 2 with a slow master: bursts back-to-back, never overlapping.
    for (int i = 0; i < 6; i++) mem2[i] = 8'($urandom);
    acc2_q.delete();
    en2 = 1'b1;
    for (int b = 0; b < 3; b++) begin
      got = 1'b0;
      for (c = 0; c < 2000 && !got; c++) begin
        @(negedge clk);
        if (sv2) got = 1'b1;
      end
      check("b2b.valid",   32'(got), 32'd1);
      check("b2b.accepts", 32'(acc2_q.size()), 32'(6 * (b + 1)));
      check("b2b.accel_x", {16'h0, ax2}, {16'h0, mem2[0], mem2[1]});
      check("b2b.accel_y", {16'h0, ay2}, {16'h0, mem2[2], mem2[3]});
      check("b2b.accel_z", {16'h0, az2}, {16'h0, mem2[4], mem2[5]});
      check("b2b.shake",   32'(sh2), 32'd0);
      check("b2b.error",   32'(err2), 32'd0);
      c = 0;
      while (!busy2 && c < 10) begin
        @(negedge clk);
        c++;
      end
      check("b2b.gap", 32'(c >= 1 && c <= 3), 32'd1);
    end
    for (int i = 0; i < 18; i++) begin
      if (i < acc2_q.size()) check("b2b.addr", {24'h0, acc2_q[i]}, 32'h3B + 32'(i % 6));
    end
    en2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mpu6050_sampler.md
# mpu6050_sampler

Periodic accelerometer sampler sitting directly above `i2c_master` in the gyroscope sensor path. When enabled, it issues six single-register reads (ACCEL_XOUT_H through ACCEL_ZOUT_L, 0x3B–0x40) through the master's start/data_in/data_out handshake. It assembles the bytes into three signed 16-bit axis words and flags shakes for the game logic. The block is the sole driver of the master's `start` and `data_in`.

## Interface
- `SAMPLE_PERIOD`, default 5_000_000: clk cycles between sample bursts (100 ms at 50 MHz); must be ≥ 2.
- `TIMEOUT_CYCLES`, default 500_000: max cycles to wait for one byte before aborting.
- `SHAKE_THRESHOLD`, default 16'd8000: minimum |Δ| on X or Y between consecutive samples that counts as a shake.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable_giroscopio`  in  1  gates new bursts; a burst in progress always completes.
- `master_available`  in  1  `i2c_master_available`; high = master idle and accepting `start`.
- `master_data_valid`  in  1  `data_out_available`; one-cycle pulse, `master_data` valid in that cycle.
- `master_data`  in  8  byte read from the MPU6050.
- `master_start`  out  1  request to master; to `start`.
- `master_reg_addr`  out  8  register to read; to `data_in`.
- `accel_x`, `accel_y`, `accel_z`  out  16 each  signed two's-complement samples, big-endian assembled (H<<8 | L).
- `sample_valid`  out  1  one-cycle pulse when all three axes have updated.
- `shake_detected`  out  1  one-cycle pulse, coincident with `sample_valid`.
- `busy`  out  1  high from leaving IDLE until return to IDLE.
- `i2c_error`  out  1  sticky timeout flag; cleared by reset or by the next successful burst.

## Operation
- Period counter free-runs 0..SAMPLE_PERIOD-1; the wrap cycle is the `tick`.
- FSM states:
  - IDLE: waits for `tick` && `enable_giroscopio`, then sets byte index 0 and goes to REQ.
  - REQ: drives `master_reg_addr` = 0x3B + index. Asserts `master_start` while `master_available` is high. Goes to WAIT on the first cycle `master_available` is low after `start` was asserted.
  - WAIT: on `master_data_valid`, latches the byte into the shadow register [index] and goes to NEXT.
  - NEXT: if index = 5, goes to DONE; otherwise increments index and goes to REQ.
  - DONE: copies the shadow registers to `accel_*` simultaneously, pulses `sample_valid`, evaluates shake, clears `i2c_error`, returns to IDLE.
  - ERR: entered from REQ or WAIT when the per-byte timeout counter reaches TIMEOUT_CYCLES. Sets `i2c_error`, drops `master_start`, returns to IDLE next cycle. `accel_*` are left unchanged and no `sample_valid` is issued.
- The timeout counter clears on every entry to REQ.
- `master_reg_addr` holds its value through WAIT. In IDLE it shows 0x3B.
- Shake check:
  - Compute 17-bit signed differences new−previous for X and Y, then absolute value.
  - Shake fires if either |Δ| > SHAKE_THRESHOLD.
  - The first valid sample after reset never fires shake (`prev_valid` flag).
  - The previous-sample registers update on every DONE.
- `tick` while busy is ignored; it is not queued.
- `enable_giroscopio` falling mid-burst does not abort the burst.

## Timing
- Reset values:
  - `master_start`, `sample_valid`, `shake_detected`, `busy`, `i2c_error` = 0.
  - `accel_*` = 0.
  - `master_reg_addr` = 0x3B.
  - FSM = IDLE; counters = 0.
- Reset assertion mid-burst aborts immediately. The master sees `start` drop asynchronously.
- `master_start` rises the cycle after entry to REQ (registered). It falls in the same cycle the FSM leaves REQ.
- `master_data` is captured on the cycle `master_data_valid` is high; no extra wait.
- `sample_valid`/`shake_detected` are registered, asserting one cycle after the DONE state is entered.
- Best-case burst = 6 × (master transaction + 3) + 2 cycles.
- A `master_data_valid` pulse outside WAIT is ignored.

## Structure
- Shared `mpu6050_pkg`:
  - register address constants (ACCEL_XOUT_H 0x3B … ACCEL_ZOUT_L 0x40, PWR_MGMT_1 0x6B, default slave address 7'h68);
  - FSM state encoding.
- One natural sub-module: `period_tick`, a parameterised free-running counter with a one-cycle tick output. It is reused by other sensor samplers.
- The top is instantiated next to `i2c_master` in the sensor wrapper; its master_* ports connect to the master one-to-one.

## Test plan
- Behavioural master model (3-cycle latency) returns 0x12,0x34,0xFE,0xDC,0x40,0x00 → `accel_x`=0x1234, `accel_y`=0xFEDC (−292), `accel_z`=0x4000, one `sample_valid` pulse, `i2c_error`=0.
- Check the request sequence → `master_reg_addr` steps 0x3B..0x40 in order, exactly one `start` accepted per byte.
- Two bursts with X = 0x0000 then 0x2000 (Δ = 8192 > 8000) → `shake_detected` pulses on the second only. Repeat with Δ = 8000 → no pulse. First burst after reset → no pulse even with large X.
- Model never pulses `data_out_available` on byte 3 → after TIMEOUT_CYCLES, `i2c_error`=1 and `accel_*` unchanged. The next good burst clears `i2c_error`.
- Drop `enable_giroscopio` during byte 2 → burst completes and `sample_valid` fires; no further bursts. Assert `reset` low during WAIT → all outputs return to reset values within the same cycle.
- SAMPLE_PERIOD=2 with slow master → ticks during busy are ignored; bursts are back-to-back, none overlapping.
